// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding and byte-lane geometry.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WORD = 2'd1,
        WRITE     = 2'd2,
        FINISH    = 2'd3
    } state_e;

    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = $clog2(LANES);

endpackage

// File: rtl/imem_byte_serializer.sv
// Holds one 32-bit word and presents it as four big-endian bytes, one lane per step.
module imem_byte_serializer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [31:0]       word_i,
    output logic [7:0]        byte_o,
    output logic [LANE_W-1:0] lane_o,
    output logic              last_lane_o
);

    logic [31:0]       word_q;
    logic [LANE_W-1:0] lane_q;
    logic [LANE_W-1:0] lane_d;

    // Word storage is pure data; only the lane index needs a reset.
    always_ff @(posedge clk) begin
        if (load_i) begin
            word_q <= word_i;
        end
    end

    always_comb begin
        lane_d = lane_q;
        if (load_i) begin
            lane_d = '0;
        end else if (step_i) begin
            lane_d = lane_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q <= '0;
        end else begin
            lane_q <= lane_d;
        end
    end

    always_comb begin
        case (lane_q)
            2'd0:    byte_o = word_q[31:24];
            2'd1:    byte_o = word_q[23:16];
            2'd2:    byte_o = word_q[15:8];
            default: byte_o = word_q[7:0];
        endcase
    end

    assign lane_o      = lane_q;
    assign last_lane_o = (lane_q == LANE_W'(LANES - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory, big-endian.
// Optional running word checksum output when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 128,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_word,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       word_count
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(MEM_BYTES - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [15:0]       wcnt_q, wcnt_d;
    logic              err_q, err_d;
    logic              last_q, last_d;
    logic              load, step;
    logic [7:0]        ser_byte;
    logic [LANE_W-1:0] ser_lane;
    logic              ser_last_lane;
    logic              accept;
    logic              fits;

    imem_byte_serializer u_ser (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .step_i      (step),
        .word_i      (in_word),
        .byte_o      (ser_byte),
        .lane_o      (ser_lane),
        .last_lane_o (ser_last_lane)
    );

    assign accept = in_valid && (state_q == WAIT_WORD);
    // Widened by one bit so a pointer near the top of the address space cannot wrap past the check.
    assign fits   = (({1'b0, ptr_q} + (ADDR_W + 1)'(LANES - 1)) <= LIMIT);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        wcnt_d   = wcnt_q;
        err_d    = err_q;
        last_d   = last_q;
        load     = 1'b0;
        step     = 1'b0;
        in_ready = 1'b0;
        mem_we   = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (base_addr[1:0] == 2'b00) begin
                        state_d = WAIT_WORD;
                        ptr_d   = base_addr;
                        wcnt_d  = '0;
                    end else begin
                        state_d = FINISH;
                        err_d   = 1'b1;
                    end
                end
            end
            WAIT_WORD: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (fits) begin
                        state_d = WRITE;
                        load    = 1'b1;
                        last_d  = in_last;
                    end else begin
                        state_d = FINISH;
                        err_d   = 1'b1;
                    end
                end
            end
            WRITE: begin
                mem_we = 1'b1;
                step   = 1'b1;
                if (ser_last_lane) begin
                    ptr_d   = ptr_q + ADDR_W'(LANES);
                    wcnt_d  = wcnt_q + 16'd1;
                    state_d = last_q ? FINISH : WAIT_WORD;
                end
            end
            default: begin
                done    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    assign mem_addr   = (state_q == WRITE) ? (ptr_q + ADDR_W'(ser_lane)) : '0;
    assign mem_wdata  = (state_q == WRITE) ? ser_byte : 8'h00;
    assign busy       = (state_q != IDLE);
    assign err        = err_q;
    assign word_count = wcnt_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
    logic [31:0] pend_q, pend_d;

    // The sum including the in-flight word is staged and only published once its last byte lands.
    always_comb begin
        csum_d = csum_q;
        pend_d = pend_q;
        if (state_q == IDLE && start && base_addr[1:0] == 2'b00) begin
            csum_d = '0;
            pend_d = '0;
        end else if (accept && fits) begin
            pend_d = csum_q + in_word;
        end else if (state_q == WRITE && ser_last_lane) begin
            csum_d = pend_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
            pend_q <= '0;
        end else begin
            csum_q <= csum_d;
            pend_q <= pend_d;
        end
    end

    assign checksum = csum_q;
`endif

endmodule
